// File: rtl/count_share_pkg.sv
// Shared definitions for the count_share_arb block: FSM state encodings
// and default widths used by the arbiter top and its round-robin picker.
package count_share_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CS_N    = 8;
    localparam int CS_NREQ = 4;
    localparam int CS_IDW  = 2;

endpackage

// File: rtl/count_share_arb_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (request bits), ptr (last grant), sel (winner), any_req.
module rr_pick
    import count_share_pkg::*;
#(
    parameter int NREQ = CS_NREQ,
    parameter int IDW  = CS_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  sel,
    output logic            any_req
);

    // Walk upward from ptr+1, wrapping, and take the first set bit.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!any_req && req[idx]) begin
                sel     = IDW'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_share_arb.sv
// Round-robin arbiter sharing one N-bit up-counter among NREQ requesters.
// Ports: clk, clr_n (async low reset), req, tc (flattened terminal counts),
//        gnt (one-hot owner), busy, count, done (pulse), done_id.
module count_share_arb
    import count_share_pkg::*;
#(
    parameter int N    = CS_N,
    parameter int NREQ = CS_NREQ,
    parameter int IDW  = CS_IDW
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] tc,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [N-1:0]      count,
    output logic [NREQ-1:0]   done,
    output logic [IDW-1:0]    done_id
);

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [N-1:0]    r_cnt;
    logic [N-1:0]    r_tcq;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_done_id;

    logic [IDW-1:0]  w_sel;
    logic            w_any;
    logic            w_owner_req;
    logic            w_at_tc;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req),
        .ptr     (r_ptr),
        .sel     (w_sel),
        .any_req (w_any)
    );

    // The pointer doubles as the current owner index while counting.
    assign w_owner_req = req[r_ptr];
    assign w_at_tc     = (r_cnt == r_tcq);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_done    <= '0;
            r_cnt     <= '0;
            r_tcq     <= '0;
            r_ptr     <= IDW'(NREQ - 1);
            r_done_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= NREQ'(1) << w_sel;
                        r_tcq   <= tc[w_sel*N +: N];
                        r_cnt   <= '0;
                        r_ptr   <= w_sel;
                        r_state <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    // Cancel takes priority over reaching terminal count.
                    if (!w_owner_req) begin
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_at_tc) begin
                        r_done    <= r_gnt;
                        r_done_id <= r_ptr;
                        r_gnt     <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_done  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = (r_state == S_COUNT);
    assign count   = r_cnt;
    assign done    = r_done;
    assign done_id = r_done_id;

endmodule

// File: tb/tb_count_share_arb.sv
// Directed bench for count_share_arb with grant/done scoreboards.
// Expected grant owners and done pulses are queued as stimulus is applied.
module tb_count_share_arb;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic [IDW-1:0]  id;
    } done_exp_t;

    logic              clk;
    logic              clr_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] tc;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [N-1:0]      count;
    logic [NREQ-1:0]   done;
    logic [IDW-1:0]    done_id;

    int checks   = 0;
    int failures = 0;

    int        gq[$];
    done_exp_t dq[$];
    logic [NREQ-1:0] prev_gnt;

    count_share_arb #(
        .N    (N),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (req),
        .tc      (tc),
        .gnt     (gnt),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .done_id (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: pops scoreboards on grant rise and done pulses, checks invariants.
    always @(posedge clk) begin
        #1;
        if (clr_n) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("done_onehot0", 32'($onehot0(done)), 32'd1);
            chk("gnt_done_overlap", 32'(gnt & done), 32'd0);
            if (gnt != '0 && prev_gnt == '0) begin
                chk("grant_expected", 32'(gq.size() != 0), 32'd1);
                if (gq.size() != 0) chk("grant_owner", 32'(gnt), 32'(oh(gq.pop_front())));
            end
            if (done != '0) begin
                chk("done_expected", 32'(dq.size() != 0), 32'd1);
                if (dq.size() != 0) begin
                    done_exp_t e;
                    e = dq.pop_front();
                    chk("done_vec", 32'(done), 32'(e.done));
                    chk("done_id_sb", 32'(done_id), 32'(e.id));
                end
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        prev_gnt = '0;
        clr_n = 1'b0;
        req   = '0;
        tc    = '0;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        clr_n = 1'b1;
        tick();

        // Single request, tc=3.
        req[2] = 1'b1;
        tc[2*N +: N] = 8'd3;
        gq.push_back(2);
        dq.push_back('{done: 4'b0100, id: 2'd2});
        tick();
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_busy", 32'(busy), 32'd1);
        for (int c = 0; c <= 3; c++) begin
            chk("single_count", 32'(count), 32'(c));
            chk("single_gnt_hold", 32'(gnt), 32'b0100);
            tick();
        end
        chk("single_done", 32'(done), 32'b0100);
        chk("single_done_id", 32'(done_id), 32'd2);
        chk("single_gnt_off", 32'(gnt), 32'd0);
        chk("single_busy_off", 32'(busy), 32'd0);
        chk("single_count_hold", 32'(count), 32'd3);
        req = '0;
        tick();
        chk("single_done_clr", 32'(done), 32'd0);
        chk("single_count_clr", 32'(count), 32'd0);
        chk("single_done_id_held", 32'(done_id), 32'd2);

        // Zero terminal count.
        req[1] = 1'b1;
        tc[1*N +: N] = 8'd0;
        gq.push_back(1);
        dq.push_back('{done: 4'b0010, id: 2'd1});
        tick();
        chk("zero_gnt", 32'(gnt), 32'b0010);
        tick();
        chk("zero_done", 32'(done), 32'b0010);
        chk("zero_gnt_off", 32'(gnt), 32'd0);
        req = '0;
        tick();

        // Async reset mid-count.
        req[0] = 1'b1;
        tc[0 +: N] = 8'd20;
        gq.push_back(0);
        tick();
        for (int c = 0; c < 5; c++) tick();
        chk("prerst_count", 32'(count), 32'd5);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        req = 4'b1111;
        tc = {8'd1, 8'd1, 8'd1, 8'd1};
        tick();
        chk("arst_hold_gnt", 32'(gnt), 32'd0);
        #2 clr_n = 1'b1;

        // Fairness: all requesting, tc=1 everywhere.
        for (int i = 0; i < 5; i++) begin
            gq.push_back(i % NREQ);
            dq.push_back('{done: oh(i % NREQ), id: IDW'(i % NREQ)});
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("rr_gnt", 32'(gnt), 32'(oh(i % NREQ)));
            chk("rr_count0", 32'(count), 32'd0);
            tick();
            chk("rr_gnt2", 32'(gnt), 32'(oh(i % NREQ)));
            chk("rr_count1", 32'(count), 32'd1);
            tick();
            chk("rr_done", 32'(done), 32'(oh(i % NREQ)));
            if (i == 4) req = '0;
            tick();
            chk("rr_gap", 32'(gnt), 32'd0);
            tick();
        end
        chk("rr_idle", 32'(gnt), 32'd0);

        // Cancel: requester 3 granted, drops at count 4; requester 0 pending.
        req = 4'b1001;
        tc[3*N +: N] = 8'd10;
        tc[0 +: N] = 8'd2;
        gq.push_back(3);
        tick();
        chk("cancel_gnt", 32'(gnt), 32'b1000);
        for (int c = 0; c < 4; c++) tick();
        chk("cancel_count4", 32'(count), 32'd4);
        req = 4'b0001;
        gq.push_back(0);
        dq.push_back('{done: 4'b0001, id: 2'd0});
        tick();
        chk("cancel_gnt_off", 32'(gnt), 32'd0);
        chk("cancel_count", 32'(count), 32'd0);
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_no_done", 32'(done), 32'd0);
        tick();
        chk("after_cancel_gnt", 32'(gnt), 32'b0001);
        tc[0 +: N] = 8'd7;
        tick();
        tick();
        chk("tc_sampled_count", 32'(count), 32'd2);
        tick();
        chk("tc_sampled_done", 32'(done), 32'b0001);
        req = '0;
        tick();

        // Full range tc=255.
        req[0] = 1'b1;
        tc[0 +: N] = 8'hFF;
        gq.push_back(0);
        dq.push_back('{done: 4'b0001, id: 2'd0});
        tick();
        for (int c = 0; c < 255; c++) tick();
        chk("full_count", 32'(count), 32'hFF);
        chk("full_gnt", 32'(gnt), 32'b0001);
        tick();
        chk("full_done", 32'(done), 32'b0001);
        chk("full_count_nowrap", 32'(count), 32'hFF);
        req = '0;
        tick();
        tick();

        chk("gq_drained", 32'(gq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_share_arb.md
Name: count_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one N-bit up-counter between NREQ requesters.
- Each requester asks for a timed interval by asserting req with a terminal count (tc).
- The block grants the counter to one requester, counts from 0 up to that tc, pulses done to the owner, then re-arbitrates.
- It sits between client timing logic and the shared counter datapath. All logic is posedge clk.

Parameters:
- N, 8, counter and terminal-count width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- tc  input  NREQ*N  flattened terminal counts; requester i uses tc[i*N +: N].
- gnt  output  NREQ  one-hot grant; all zero when the counter is unowned.
- busy  output  1  high while the counter is owned (state COUNT).
- count  output  N  current shared counter value.
- done  output  NREQ  one-cycle completion pulse to the owner.
- done_id  output  IDW  index of the most recent completed requester; held until the next completion.

Behaviour:
- Reset: clr_n low asynchronously forces the following, regardless of clk:
  - state IDLE, gnt=0, busy=0, count=0, done=0, done_id=0.
  - last-grant pointer = NREQ-1, so req[0] wins first after reset.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from (pointer+1) mod NREQ.
  - On the next edge: gnt=onehot(sel), tc_q=tc[sel], count=0, pointer=sel, busy=1, state COUNT.
  - Latency: req seen at edge k gives gnt high after edge k.
- COUNT, count != tc_q: count increments by 1 each edge.
- COUNT, count == tc_q: next edge sets done[owner]=1, done_id=owner, gnt=0, busy=0, state DONE. count holds its value.
- DONE:
  - Next edge clears done, sets count=0, state IDLE.
  - A pending request is granted on the following edge, giving a minimum 2-cycle gap between grants.
- Grant length: gnt is high for exactly tc_q+1 cycles. tc=0 gives a 1-cycle grant, then done.
- Owner drops req during COUNT (cancel): next edge gives gnt=0, busy=0, count=0, state IDLE, no done pulse, done_id unchanged. The pointer still advances, so the canceller is not favoured.
- Cancel and terminal count on the same cycle: cancel wins, no done.
- tc is sampled only at grant; later changes to tc[owner] are ignored.
- Requests from non-owners are not latched; a requester must hold req until granted.
- Width rules:
  - count never wraps, since it stops at tc_q <= 2^N-1. tc=2^N-1 gives 2^N grant cycles.
  - Comparison is unsigned, N bits.
- Invariants: gnt and done are each at most one-hot and are never both high for the same requester in the same cycle.

Decomposition:
- Shared package count_share_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_COUNT=2'd1, S_DONE=2'd2.
  - default widths N, NREQ, IDW.
- One natural sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req, pointer.
  - Outputs: sel index, any_req.
  - Instantiated once.
- The counter register stays inline in the top module.

Test Plan:
- Reset: hold clr_n low mid-COUNT with count=5 -> gnt=0, busy=0, count=0, done=0 immediately, without waiting for clk. After release, req=4'b1111 -> gnt=4'b0001.
- Single request: req[2]=1, tc[2]=3 at edge 0 -> gnt=4'b0100 after edge 1 with count 0,1,2,3 over edges 1-4. done=4'b0100 and done_id=2 for one cycle after edge 5, gnt=0.
- Zero terminal count: req[1]=1, tc[1]=0 -> gnt high for 1 cycle, then done[1] pulse.
- Round-robin fairness: req=4'b1111 held, all tc=1 -> grant order 0,1,2,3,0. Each grant is 2 cycles with a 2-cycle gap.
- Cancel: req[3] granted with tc=10, drop req[3] at count=4 -> gnt=0 and count=0 next edge, no done, state IDLE. Next grant goes to req[0] if pending.
- Full range: tc[0]=8'hFF -> 256 grant cycles, count reaches 8'hFF without wrap, then done[0].
